// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the fetch sequencer's control, PC-register, instruction-memory and
//   instruction-register signals.
//
//   Signals
//     start     execute -> seq  begin fetching from the current PC (IDLE only)
//     stall     execute -> seq  execute not ready; holds the sequencer after a load
//     jumpEn    execute -> seq  redirect request
//     jumpAddr  execute -> seq  redirect target
//     pcOut     PC reg  -> seq  current PC value
//     pcWrEn    seq -> PC reg   load pcDataIn into the PC
//     pcIncEn   seq -> PC reg   increment the PC
//     pcDataIn  seq -> PC reg   PC load value (0 unless pcWrEn)
//     memRdEn   seq -> memory   one-cycle read strobe
//     memAddr   seq -> memory   read address (always pcOut)
//     memData   memory -> seq   read data, valid MEM_LATENCY cycles after memRdEn
//     irOut     seq -> execute  instruction register
//     insValid  seq -> execute  one-cycle pulse: irOut holds a new instruction
//     halted    seq -> execute  high while halted
//
//   Modports
//     master  the fetch sequencer
//     slave   the surrounding core (execute, PC register, memory)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned INS_WIDTH  = 8
);
    logic                  start;
    logic                  stall;
    logic                  jumpEn;
    logic [ADDR_WIDTH-1:0] jumpAddr;
    logic [ADDR_WIDTH-1:0] pcOut;
    logic                  pcWrEn;
    logic                  pcIncEn;
    logic [ADDR_WIDTH-1:0] pcDataIn;
    logic                  memRdEn;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [INS_WIDTH-1:0]  memData;
    logic [INS_WIDTH-1:0]  irOut;
    logic                  insValid;
    logic                  halted;

    modport master (
        input  start, stall, jumpEn, jumpAddr, pcOut, memData,
        output pcWrEn, pcIncEn, pcDataIn, memRdEn, memAddr,
               irOut, insValid, halted
    );

    modport slave (
        output start, stall, jumpEn, jumpAddr, pcOut, memData,
        input  pcWrEn, pcIncEn, pcDataIn, memRdEn, memAddr,
               irOut, insValid, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Fetch-stage controller for one core. Drives the external PC register's
//   write/increment enables, issues an instruction-memory read at the current
//   PC, waits the fixed memory latency and loads the instruction register.
//   Handles jump redirects, stall back-pressure from execute and a halt opcode.
//
//   Parameters
//     ADDR_WIDTH   width of PC and memory address
//     INS_WIDTH    width of instruction word / IR
//     MEM_LATENCY  cycles from the memRdEn cycle to memData valid (1..8)
//     HALT_OPCODE  instruction value that stops fetching
//
//   Ports
//     clk   system clock, all state on the rising edge
//     rstN  asynchronous active-low reset
//     bus   fetch_sequencer_if master modport (see interface file)
//
//   Fetch cycle: ISSUE -> WAIT x (MEM_LATENCY-1) -> LOAD, so an unstalled
//   instruction stream runs at one instruction every MEM_LATENCY+1 cycles.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH  = 12,
    parameter int unsigned           INS_WIDTH   = 8,
    parameter int unsigned           MEM_LATENCY = 2,
    parameter logic [INS_WIDTH-1:0]  HALT_OPCODE = 8'hFF
) (
    input  logic                clk,
    input  logic                rstN,
    fetch_sequencer_if.master   bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LOAD,
        S_HOLD,
        S_HALT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [INS_WIDTH-1:0]   r_ir;
    logic                   r_ins_valid;

    logic                   w_jump;
    logic                   w_is_halt_op;
    logic                   w_ir_load;

    // A jump is only honoured while a fetch is in progress or held.
    always_comb begin
        w_jump = 1'b0;
        if (bus.jumpEn) begin
            case (r_state)
                S_ISSUE, S_WAIT, S_LOAD, S_HOLD: w_jump = 1'b1;
                default:                         w_jump = 1'b0;
            endcase
        end
    end

    assign w_is_halt_op = (bus.memData == HALT_OPCODE);

    // A jump in LOAD discards the instruction being returned.
    assign w_ir_load = (r_state == S_LOAD) && !w_jump;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_jump) begin
                    w_next_state = S_ISSUE;
                end else if (MEM_LATENCY <= 1) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_jump) begin
                    w_next_state = S_ISSUE;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                // Jump beats halt detection, halt beats stall.
                if (w_jump) begin
                    w_next_state = S_ISSUE;
                end else if (w_is_halt_op) begin
                    w_next_state = S_HALT;
                end else if (bus.stall) begin
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (w_jump || !bus.stall) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        bus.memRdEn  = 1'b0;
        bus.pcWrEn   = 1'b0;
        bus.pcIncEn  = 1'b0;
        bus.pcDataIn = '0;
        bus.halted   = 1'b0;
        case (r_state)
            S_ISSUE: begin
                bus.memRdEn = 1'b1;
            end
            S_LOAD: begin
                bus.pcIncEn = !w_jump && !w_is_halt_op;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
            end
        endcase
        // Write has priority; pcIncEn is already suppressed on a jump.
        if (w_jump) begin
            bus.pcWrEn   = 1'b1;
            bus.pcDataIn = bus.jumpAddr;
        end
    end

    assign bus.memAddr  = bus.pcOut;
    assign bus.irOut    = r_ir;
    assign bus.insValid = r_ins_valid;

    // ------------------------------------------------------------------------
    // Latency counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Instruction register and valid pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ir        <= '0;
            r_ins_valid <= 1'b0;
        end else begin
            r_ins_valid <= w_ir_load;
            if (w_ir_load) begin
                r_ir <= bus.memData;
            end
        end
    end

endmodule
